// File: rtl/priority_decode24_grant_if.sv
// Request/grant bundle for the 2-to-4 grant decoder.
// The requester side (master) presents an index and a release strobe.
// The decoder side (slave) returns the one-hot grant and status.
interface priority_decode24_grant_if;
  logic [1:0] a;
  logic       a_valid;
  logic       a_ready;
  logic       done;
  logic [3:0] d;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output a, a_valid, done,
    input  a_ready, d, grant_idx, busy, timeout
  );

  modport slave (
    input  a, a_valid, done,
    output a_ready, d, grant_idx, busy, timeout
  );
endinterface

// File: rtl/priority_decode24_grant.sv
// Registered 2-to-4 grant decoder.
// Accepts a 2-bit index through a valid/ready handshake and drives the
// matching one-hot grant line. A grant lasts until done or until the hold
// timer runs out, and every grant is followed by one all-zero cycle before
// the next one starts. One extra request can be parked while a grant is on.
module priority_decode24_grant #(
  parameter int HOLD_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  priority_decode24_grant_if.slave bus
);
  // Counter is loaded with HOLD_CYCLES-1 so that zero marks the last cycle.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] pend_idx_reg, pend_idx_next;
  logic       pend_v_reg, pend_v_next;
  logic [3:0] d_reg, d_next;
  logic [1:0] grant_idx_reg, grant_idx_next;
  logic       timeout_reg, timeout_next;

  logic       accept;
  logic       start_grant;
  logic [1:0] start_idx;
  logic [3:0] start_onehot;

  // While granting, ready only if the parking slot is free; never in reset.
  assign bus.a_ready = !rst && ((state_reg == IDLE) || !pend_v_reg);
  assign accept      = bus.a_valid && bus.a_ready;

  // Decide whether a new grant begins at the next edge and for which index;
  // a parked request in GAP takes precedence over a fresh one.
  always_comb begin
    start_grant = 1'b0;
    start_idx   = bus.a;
    case (state_reg)
      IDLE: start_grant = accept;
      GAP: begin
        start_grant = pend_v_reg || accept;
        start_idx   = pend_v_reg ? pend_idx_reg : bus.a;
      end
      default: ;
    endcase
  end

  // One-hot decode of the index that is about to be granted.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
      assign start_onehot[gi] = (start_idx == 2'(gi));
    end
  endgenerate

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pend_idx_next  = pend_idx_reg;
    pend_v_next    = pend_v_reg;
    d_next         = d_reg;
    grant_idx_next = grant_idx_reg;
    timeout_next   = 1'b0;

    if (start_grant) begin
      state_next     = GRANT;
      grant_idx_next = start_idx;
      d_next         = start_onehot;
      cnt_next       = HOLD_LOAD;
    end

    case (state_reg)
      IDLE: ;
      GRANT: begin
        // done beats a simultaneous timer expiry, so no timeout pulse then.
        if (bus.done) begin
          state_next = GAP;
          d_next     = 4'b0000;
        end else if (cnt_reg == 8'd0) begin
          state_next   = GAP;
          d_next       = 4'b0000;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
        if (accept) begin
          pend_idx_next = bus.a;
          pend_v_next   = 1'b1;
        end
      end
      GAP: begin
        // The parked request (if any) is consumed by the grant starting now.
        pend_v_next = 1'b0;
        if (!start_grant) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      pend_idx_reg  <= 2'd0;
      pend_v_reg    <= 1'b0;
      d_reg         <= 4'b0000;
      grant_idx_reg <= 2'd0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pend_idx_reg  <= pend_idx_next;
      pend_v_reg    <= pend_v_next;
      d_reg         <= d_next;
      grant_idx_reg <= grant_idx_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.d         = d_reg;
  assign bus.grant_idx = grant_idx_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_priority_decode24_grant.sv
// Self-checking bench for priority_decode24_grant.
// dut4 (hold 4) is the main target and is tracked by a cycle model;
// dut3 (hold 3) shares the same inputs and is used for the done/expiry race.
module tb_priority_decode24_grant;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a;
  logic       a_valid;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_decode24_grant_if bus4 ();
  priority_decode24_grant_if bus3 ();

  assign bus4.a       = a;
  assign bus4.a_valid = a_valid;
  assign bus4.done    = done;
  assign bus3.a       = a;
  assign bus3.a_valid = a_valid;
  assign bus3.done    = done;

  priority_decode24_grant #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  priority_decode24_grant #(.HOLD_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Reference model for dut4: a grant is "active" with an age in cycles,
  // followed by one gap cycle; parked requests live in a queue.
  bit m_active, m_gap, m_to;
  int m_age;
  int m_idx;
  int m_pend[$];

  function automatic bit model_ready();
    return !rst && (!(m_active || m_gap) || m_pend.size() == 0);
  endfunction

  function automatic logic [3:0] model_d();
    return m_active ? (4'b0001 << m_idx) : 4'b0000;
  endfunction

  function automatic void model_step();
    bit acc;
    acc  = a_valid && model_ready();
    m_to = 1'b0;
    if (rst) begin
      m_active = 0; m_gap = 0; m_age = 0; m_idx = 0;
      m_pend.delete();
    end else if (m_active) begin
      if (acc) m_pend.push_back(int'(a));
      if (done) begin
        m_active = 0; m_gap = 1;
      end else if (m_age >= HOLD) begin
        m_active = 0; m_gap = 1; m_to = 1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (m_pend.size() > 0) begin
        m_idx = m_pend.pop_front(); m_active = 1; m_age = 1;
      end else if (acc) begin
        m_idx = int'(a); m_active = 1; m_age = 1;
      end
    end else if (acc) begin
      m_idx = int'(a); m_active = 1; m_age = 1;
    end
  endfunction

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    rst = 0; a_valid = 0; done = 1;
    for (int i = 0; i < 6; i++) adv();
    done = 0;
    adv();
  endtask

  task automatic test_reset();
    rst = 1; a_valid = 1; a = 2'd2; done = 0;
    for (int i = 0; i < 2; i++) begin
      adv();
      @(negedge clk);
      n_checks++;
      if (bus4.d !== 4'b0000 || bus4.busy !== 1'b0 || bus4.a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: d=%b busy=%b a_ready=%b expected d=0000 busy=0 a_ready=0",
                 bus4.d, bus4.busy, bus4.a_ready);
      end
    end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (bus4.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: a_ready=%b expected 1", bus4.a_ready);
    end
    adv();
    a_valid = 0;
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0100 || bus4.grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_first_grant: d=%b idx=%0d expected d=0100 idx=2", bus4.d, bus4.grant_idx);
    end
    $display("reset: request a=2 granted d=%b", bus4.d);
    done = 1; adv(); done = 0; adv();
  endtask

  task automatic test_basic();
    logic [3:0] exp_d;
    settle();
    for (int v = 0; v < 4; v++) begin
      exp_d = 4'b0001 << v;
      a = 2'(v); a_valid = 1;
      adv();
      a_valid = 0;
      for (int c = 0; c < 2; c++) begin
        if (c == 1) done = 1;
        @(negedge clk);
        n_checks++;
        if (bus4.d !== exp_d || bus4.timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_grant a=%0d cyc=%0d: d=%b timeout=%b expected d=%b timeout=0",
                   v, c, bus4.d, bus4.timeout, exp_d);
        end
        adv();
      end
      done = 0;
      @(negedge clk);
      n_checks++;
      if (bus4.d !== 4'b0000 || bus4.timeout !== 1'b0 || bus4.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_gap a=%0d: d=%b timeout=%b busy=%b expected d=0000 timeout=0 busy=1",
                 v, bus4.d, bus4.timeout, bus4.busy);
      end
      adv();
      @(negedge clk);
      n_checks++;
      if (bus4.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_idle a=%0d: busy=%b expected 0", v, bus4.busy);
      end
      $display("basic: a=%0d granted d=%b then released", v, exp_d);
    end
  endtask

  task automatic test_timeout();
    settle();
    a = 2'd3; a_valid = 1;
    adv();
    a_valid = 0;
    for (int c = 0; c < HOLD; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus4.d !== 4'b1000 || bus4.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold cyc=%0d: d=%b timeout=%b expected d=1000 timeout=0",
                 c, bus4.d, bus4.timeout);
      end
      adv();
    end
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0000 || bus4.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: d=%b timeout=%b expected d=0000 timeout=1", bus4.d, bus4.timeout);
    end
    adv();
    @(negedge clk);
    n_checks++;
    if (bus4.timeout !== 1'b0 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_end: timeout=%b busy=%b expected 0 0", bus4.timeout, bus4.busy);
    end
    $display("timeout: a=3 held %0d cycles then timed out", HOLD);
  endtask

  task automatic test_pending();
    settle();
    a = 2'd1; a_valid = 1;
    adv();
    a = 2'd2;
    @(negedge clk);
    n_checks++;
    if (bus4.a_ready !== 1'b1 || bus4.d !== 4'b0010) begin
      n_fail++;
      $display("FAIL pend_accept: a_ready=%b d=%b expected 1 0010", bus4.a_ready, bus4.d);
    end
    adv();
    a = 2'd0; done = 1;
    @(negedge clk);
    n_checks++;
    if (bus4.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_full_ready: a_ready=%b expected 0", bus4.a_ready);
    end
    adv();
    done = 0;
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0000 || bus4.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_gap: d=%b a_ready=%b expected 0000 0", bus4.d, bus4.a_ready);
    end
    adv();
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0100 || bus4.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_grant: d=%b a_ready=%b expected 0100 1", bus4.d, bus4.a_ready);
    end
    adv();
    a_valid = 0; done = 1;
    adv();
    done = 0;
    adv();
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0001) begin
      n_fail++;
      $display("FAIL pend_second: d=%b expected 0001", bus4.d);
    end
    $display("pending: a=1 then a=2 (parked) then a=0 granted in order");
    done = 1; adv(); done = 0; adv();
  endtask

  task automatic test_reset_mid();
    settle();
    a = 2'd1; a_valid = 1;
    adv();
    a = 2'd3;
    adv();
    a_valid = 0; rst = 1;
    @(negedge clk);
    n_checks++;
    if (bus4.d !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_pre: d=%b expected 0010", bus4.d);
    end
    adv();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus4.d !== 4'b0000 || bus4.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_drop cyc=%0d: d=%b busy=%b expected 0000 0", c, bus4.d, bus4.busy);
      end
      adv();
    end
    $display("reset mid-grant: grant dropped, parked a=3 discarded");
  endtask

  task automatic test_simul();
    settle();
    a = 2'd1; a_valid = 1;
    adv();
    a_valid = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) done = 1;
      @(negedge clk);
      n_checks++;
      if (bus3.d !== 4'b0010) begin
        n_fail++;
        $display("FAIL simul_hold cyc=%0d: d=%b expected 0010", c, bus3.d);
      end
      adv();
    end
    done = 0;
    @(negedge clk);
    n_checks++;
    if (bus3.timeout !== 1'b0 || bus3.d !== 4'b0000 || bus3.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_done_wins: timeout=%b d=%b busy=%b expected 0 0000 1",
               bus3.timeout, bus3.d, bus3.busy);
    end
    settle();
    a = 2'd1; a_valid = 1;
    adv();
    a_valid = 0;
    for (int c = 0; c < 3; c++) adv();
    @(negedge clk);
    n_checks++;
    if (bus3.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_expiry_alone: timeout=%b expected 1", bus3.timeout);
    end
    $display("simultaneous: done on last hold cycle suppresses timeout");
  endtask

  task automatic test_random();
    int grants;
    grants = 0;
    settle();
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      a_valid = ($urandom_range(0, 2) != 0);
      a       = 2'($urandom_range(0, 3));
      done    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n_checks++;
      if (bus4.d !== model_d() || bus4.busy !== (m_active || m_gap) ||
          bus4.timeout !== m_to || bus4.grant_idx !== 2'(m_idx) ||
          bus4.a_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL random cyc=%0d: d=%b busy=%b to=%b idx=%0d rdy=%b expected d=%b busy=%b to=%b idx=%0d rdy=%b",
                 i, bus4.d, bus4.busy, bus4.timeout, bus4.grant_idx, bus4.a_ready,
                 model_d(), (m_active || m_gap), m_to, m_idx, model_ready());
      end
      if (m_active && m_age == 1) grants++;
      adv();
    end
    rst = 0; a_valid = 0; done = 0;
    $display("random: 1500 cycles, %0d grants started", grants);
  endtask

  initial begin
    rst = 1; a = 2'd0; a_valid = 0; done = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_pending();
    test_reset_mid();
    test_simul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
